// File: rtl/vx_raster_csr_bank.sv
// vx_raster_csr_bank
// Multi-stage texture CSR bank. Each stage owns a shadow set (CSR writes land
// here) and an active set (driven to the sampler). A commit waits until all
// in-flight sampler requests have retired, then copies every shadow set into
// its active set on a single edge.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   csr_wr_valid/stage/addr/data CSR write into the shadow sets
//   csr_rd_stage/addr, csr_rd_data  registered debug read of shadow (1 cycle)
//   commit_valid/ready, commit_done commit handshake, done pulses on copy cycle
//   req_fire, req_ready, rsp_fire   sampler request tracking
//   pending_cnt                 in-flight request count
//   active_csrs                 active sets, stage 0 in the LSBs
//
// Per-stage set layout (LSB first):
//   baddr[ADDR_BITS] | format | filter | wrap u,v | logdim u,v | mipoff[0..LOD_MAX]
//
// Address map: 0 baddr, 1 format, 2 filter, 3 wraps {v,u}, 4 logdims {v,u},
// 5+i mipoff[i]. Unmapped addresses are ignored on write and read as zero.
//
// state | meaning
// IDLE  | accepting commits and sampler requests
// DRAIN | commit accepted, waiting for pending_cnt==0, copy on that edge

module vx_raster_csr_bank #(
    parameter int NUM_STAGES  = 2,
    parameter int LOD_MAX     = 11,
    parameter int MIPOFF_BITS = 25,
    parameter int LOD_BITS    = 4,
    parameter int WRAP_BITS   = 2,
    parameter int ADDR_BITS   = 32,
    parameter int FORMAT_BITS = 3,
    parameter int FILTER_BITS = 1,
    parameter int MAX_PENDING = 16,
    localparam int CSR_W = (LOD_MAX + 1) * MIPOFF_BITS + 2 * LOD_BITS + 2 * WRAP_BITS
                           + ADDR_BITS + FORMAT_BITS + FILTER_BITS,
    localparam int STAGE_BITS = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int CNT_BITS   = $clog2(MAX_PENDING + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           csr_wr_valid,
    input  logic [STAGE_BITS-1:0]          csr_wr_stage,
    input  logic [7:0]                     csr_wr_addr,
    input  logic [31:0]                    csr_wr_data,
    input  logic [STAGE_BITS-1:0]          csr_rd_stage,
    input  logic [7:0]                     csr_rd_addr,
    output logic [31:0]                    csr_rd_data,
    input  logic                           commit_valid,
    output logic                           commit_ready,
    output logic                           commit_done,
    input  logic                           req_fire,
    output logic                           req_ready,
    input  logic                           rsp_fire,
    output logic [CNT_BITS-1:0]            pending_cnt,
    output logic [NUM_STAGES*CSR_W-1:0]    active_csrs
);

    localparam int BADDR_LSB  = 0;
    localparam int FORMAT_LSB = BADDR_LSB + ADDR_BITS;
    localparam int FILTER_LSB = FORMAT_LSB + FORMAT_BITS;
    localparam int WRAP_LSB   = FILTER_LSB + FILTER_BITS;
    localparam int LOG_LSB    = WRAP_LSB + 2 * WRAP_BITS;
    localparam int MIP_LSB    = LOG_LSB + 2 * LOD_BITS;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                        state;
    logic [NUM_STAGES*CSR_W-1:0]   shadow_q;
    logic [NUM_STAGES*CSR_W-1:0]   shadow_d;
    logic [NUM_STAGES*CSR_W-1:0]   active_q;
    logic [31:0]                   rd_d;
    logic [CNT_BITS-1:0]           cnt_d;

    function automatic logic [CSR_W-1:0] apply_wr(input logic [CSR_W-1:0] cur,
                                                  input logic [7:0]       addr,
                                                  input logic [31:0]      data);
        logic [CSR_W-1:0] nxt;
        nxt = cur;
        case (addr)
            8'd0: nxt[BADDR_LSB +: ADDR_BITS]    = data[ADDR_BITS-1:0];
            8'd1: nxt[FORMAT_LSB +: FORMAT_BITS] = data[FORMAT_BITS-1:0];
            8'd2: nxt[FILTER_LSB +: FILTER_BITS] = data[FILTER_BITS-1:0];
            8'd3: nxt[WRAP_LSB +: 2*WRAP_BITS]   = data[2*WRAP_BITS-1:0];
            8'd4: nxt[LOG_LSB +: 2*LOD_BITS]     = data[2*LOD_BITS-1:0];
            default: begin
                for (int i = 0; i <= LOD_MAX; i++) begin
                    if (addr == 8'(5 + i))
                        nxt[MIP_LSB + i*MIPOFF_BITS +: MIPOFF_BITS] = data[MIPOFF_BITS-1:0];
                end
            end
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] rd_field(input logic [CSR_W-1:0] cur,
                                             input logic [7:0]       addr);
        logic [31:0] val;
        val = '0;
        case (addr)
            8'd0: val = 32'(cur[BADDR_LSB +: ADDR_BITS]);
            8'd1: val = 32'(cur[FORMAT_LSB +: FORMAT_BITS]);
            8'd2: val = 32'(cur[FILTER_LSB +: FILTER_BITS]);
            8'd3: val = 32'(cur[WRAP_LSB +: 2*WRAP_BITS]);
            8'd4: val = 32'(cur[LOG_LSB +: 2*LOD_BITS]);
            default: begin
                for (int i = 0; i <= LOD_MAX; i++) begin
                    if (addr == 8'(5 + i))
                        val = 32'(cur[MIP_LSB + i*MIPOFF_BITS +: MIPOFF_BITS]);
                end
            end
        endcase
        return val;
    endfunction

    // Reads and the commit copy both see the post-edge shadow, so a write in
    // the same cycle is visible to them.
    always_comb begin
        shadow_d = shadow_q;
        rd_d     = '0;
        if (csr_wr_valid) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (csr_wr_stage == STAGE_BITS'(s))
                    shadow_d[s*CSR_W +: CSR_W] = apply_wr(shadow_q[s*CSR_W +: CSR_W],
                                                          csr_wr_addr, csr_wr_data);
            end
        end
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (csr_rd_stage == STAGE_BITS'(s))
                rd_d = rd_field(shadow_d[s*CSR_W +: CSR_W], csr_rd_addr);
        end
    end

    always_comb begin
        cnt_d = pending_cnt;
        if (req_fire && !rsp_fire)
            cnt_d = pending_cnt + CNT_BITS'(1);
        else if (rsp_fire && !req_fire && pending_cnt != '0)
            cnt_d = pending_cnt - CNT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_cnt <= '0;
            csr_rd_data <= '0;
        end else begin
            assert (!(rsp_fire && pending_cnt == '0));
            assert (!(req_fire && !req_ready));
            shadow_q    <= shadow_d;
            csr_rd_data <= rd_d;
            pending_cnt <= cnt_d;
            case (state)
                IDLE: begin
                    if (commit_valid)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pending_cnt == '0) begin
                        active_q <= shadow_d;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign commit_ready = (state == IDLE);
    assign commit_done  = (state == DRAIN) && (pending_cnt == '0);
    assign req_ready    = (state == IDLE) && (pending_cnt < CNT_BITS'(MAX_PENDING));
    assign active_csrs  = active_q;

endmodule

// File: tb/tb_vx_raster_csr_bank.sv
// Testbench for vx_raster_csr_bank. Stimulus pushes expected values tagged
// with the cycle they must appear in; a monitor on the falling edge pops and
// compares them against the DUT outputs.

module tb_vx_raster_csr_bank;

    localparam int NUM_STAGES = 2;
    localparam int CSR_W      = 348;
    localparam int CNT_BITS   = 5;

    localparam int K_RD     = 0;
    localparam int K_PEND   = 1;
    localparam int K_REQRDY = 2;
    localparam int K_CRDY   = 3;
    localparam int K_DONE   = 4;
    localparam int K_ACT    = 5;

    logic                          clk;
    logic                          reset;
    logic                          csr_wr_valid;
    logic [0:0]                    csr_wr_stage;
    logic [7:0]                    csr_wr_addr;
    logic [31:0]                   csr_wr_data;
    logic [0:0]                    csr_rd_stage;
    logic [7:0]                    csr_rd_addr;
    logic [31:0]                   csr_rd_data;
    logic                          commit_valid;
    logic                          commit_ready;
    logic                          commit_done;
    logic                          req_fire;
    logic                          req_ready;
    logic                          rsp_fire;
    logic [CNT_BITS-1:0]           pending_cnt;
    logic [NUM_STAGES*CSR_W-1:0]   active_csrs;

    vx_raster_csr_bank dut (
        .clk          (clk),
        .reset        (reset),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_stage (csr_wr_stage),
        .csr_wr_addr  (csr_wr_addr),
        .csr_wr_data  (csr_wr_data),
        .csr_rd_stage (csr_rd_stage),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_data  (csr_rd_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_done  (commit_done),
        .req_fire     (req_fire),
        .req_ready    (req_ready),
        .rsp_fire     (rsp_fire),
        .pending_cnt  (pending_cnt),
        .active_csrs  (active_csrs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        int          st;
        int          ad;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent view of the documented set layout.
    function automatic logic [31:0] act_field(input int st, input int ad);
        logic [CSR_W-1:0] set;
        set = active_csrs[st*CSR_W +: CSR_W];
        case (ad)
            0: return set[31:0];
            1: return {29'd0, set[34:32]};
            2: return {31'd0, set[35]};
            3: return {28'd0, set[39:36]};
            4: return {24'd0, set[47:40]};
            default: begin
                if (ad >= 5 && ad <= 16)
                    return {7'd0, set[48 + (ad-5)*25 +: 25]};
                return 32'd0;
            end
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k, input int st, input int ad);
        case (k)
            K_RD:     return csr_rd_data;
            K_PEND:   return 32'(pending_cnt);
            K_REQRDY: return 32'(req_ready);
            K_CRDY:   return 32'(commit_ready);
            K_DONE:   return 32'(commit_done);
            default:  return act_field(st, ad);
        endcase
    endfunction

    task automatic exp_at(input int c, input int k, input logic [31:0] e,
                          input string n, input int st = 0, input int ad = 0);
        exp_t x;
        x.cyc  = c;
        x.kind = k;
        x.st   = st;
        x.ad   = ad;
        x.exp  = e;
        x.name = n;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        bit done_ok;
        done_ok = 1'b0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                logic [31:0] a;
                a = actual(sbq[i].kind, sbq[i].st, sbq[i].ad);
                n_cmp++;
                if (sbq[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: not checked at cycle %0d (now %0d)",
                             sbq[i].name, sbq[i].cyc, cyc);
                end else if (a !== sbq[i].exp) begin
                    n_bad++;
                    $display("FAIL %s: cycle %0d actual=0x%0h required=0x%0h",
                             sbq[i].name, cyc, a, sbq[i].exp);
                end
                if (sbq[i].kind == K_DONE && sbq[i].exp == 32'd1)
                    done_ok = 1'b1;
                sbq.delete(i);
            end
        end
        if (commit_done === 1'b1 && !done_ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_commit_done: cycle %0d actual=1 required=0", cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        csr_wr_valid = 1'b0;
        commit_valid = 1'b0;
        req_fire     = 1'b0;
        rsp_fire     = 1'b0;
    endtask

    task automatic wr(input int st, input int ad, input logic [31:0] d);
        csr_wr_valid = 1'b1;
        csr_wr_stage = 1'(st);
        csr_wr_addr  = 8'(ad);
        csr_wr_data  = d;
    endtask

    task automatic rd_exp(input int st, input int ad, input logic [31:0] e, input string n);
        csr_rd_stage = 1'(st);
        csr_rd_addr  = 8'(ad);
        exp_at(cyc + 1, K_RD, e, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        csr_wr_valid = 1'b0;
        csr_wr_stage = '0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
        csr_rd_stage = '0;
        csr_rd_addr  = '0;
        commit_valid = 1'b0;
        req_fire     = 1'b0;
        rsp_fire     = 1'b0;
        repeat (3) step();

        // reset state, then first writes and reads (cycle 3)
        exp_at(cyc, K_PEND,   0, "rst_pending");
        exp_at(cyc, K_REQRDY, 1, "rst_req_ready");
        exp_at(cyc, K_CRDY,   1, "rst_commit_ready");
        exp_at(cyc, K_DONE,   0, "rst_commit_done");
        exp_at(cyc, K_RD,     0, "rst_rd_data");
        exp_at(cyc, K_ACT,    0, "rst_active_baddr", 0, 0);
        reset = 1'b0;
        wr(0, 0, 32'h1000_0000);
        rd_exp(0, 0, 32'h1000_0000, "rd_baddr_same_cycle");
        step();
        wr(0, 5, 32'h0000_0123);
        rd_exp(0, 5, 32'h0000_0123, "rd_mipoff0");
        exp_at(cyc + 1, K_ACT, 0, "active_baddr_untouched", 0, 0);
        exp_at(cyc + 1, K_ACT, 0, "active_mip0_untouched", 0, 5);
        step();
        rd_exp(0, 0, 32'h1000_0000, "rd_baddr_again");
        step();

        // commit with nothing pending (T = cycle 6)
        commit_valid = 1'b1;
        exp_at(cyc + 1, K_DONE, 1, "commit_done_T1");
        exp_at(cyc + 1, K_CRDY, 0, "commit_ready_drain");
        exp_at(cyc + 1, K_ACT,  0, "active_before_copy", 0, 0);
        exp_at(cyc + 2, K_ACT,  32'h1000_0000, "active_baddr_T2", 0, 0);
        exp_at(cyc + 2, K_ACT,  32'h0000_0123, "active_mip0_T2", 0, 5);
        exp_at(cyc + 2, K_DONE, 0, "commit_done_low_T2");
        exp_at(cyc + 2, K_CRDY, 1, "commit_ready_back");
        step();
        step();

        // commit with 3 in flight (cycle 8)
        repeat (3) begin
            req_fire = 1'b1;
            step();
        end
        exp_at(cyc, K_PEND, 3, "pending_3");
        commit_valid = 1'b1;
        step();
        exp_at(cyc, K_REQRDY, 0, "drain_req_ready");
        exp_at(cyc, K_CRDY,   0, "drain_commit_ready");
        exp_at(cyc, K_DONE,   0, "drain_no_done");
        rsp_fire = 1'b1;
        step();
        exp_at(cyc, K_PEND, 2, "drain_pending_2");
        rsp_fire = 1'b1;
        wr(1, 1, 32'h0000_0007);
        step();
        rsp_fire = 1'b1;
        step();
        exp_at(cyc, K_DONE,   1, "drain_done_after_retire");
        exp_at(cyc, K_PEND,   0, "drain_pending_0");
        exp_at(cyc, K_REQRDY, 0, "copy_cycle_req_ready");
        wr(1, 2, 32'h0000_0003);
        exp_at(cyc + 1, K_REQRDY, 1, "req_ready_after_commit");
        exp_at(cyc + 1, K_ACT, 7, "active_fmt_drain_write", 1, 1);
        exp_at(cyc + 1, K_ACT, 1, "active_filter_copy_write", 1, 2);
        exp_at(cyc + 1, K_ACT, 32'h1000_0000, "active_s0_baddr_kept", 0, 0);
        step();

        // field truncation and unmapped addresses (cycle 16)
        wr(0, 3, 32'h0000_00FF);
        rd_exp(0, 3, 32'h0000_000F, "wraps_truncated");
        step();
        wr(0, 40, 32'h0000_DEAD);
        rd_exp(0, 40, 0, "unmapped_40_reads_0");
        step();
        wr(1, 17, 32'h0000_0055);
        rd_exp(1, 17, 0, "unmapped_17_reads_0");
        step();
        wr(1, 16, 32'hFFFF_FFFF);
        rd_exp(1, 16, 32'h01FF_FFFF, "mipoff11_truncated");
        step();
        rd_exp(0, 0, 32'h1000_0000, "baddr_after_unmapped");
        step();
        rd_exp(1, 1, 32'h0000_0007, "s1_format_shadow");
        step();
        wr(0, 4, 32'h0000_1234);
        rd_exp(0, 4, 32'h0000_0034, "logdims_truncated");
        step();

        // pending counter (cycle 23)
        repeat (5) begin
            req_fire = 1'b1;
            step();
        end
        exp_at(cyc, K_PEND, 5, "pending_5");
        req_fire = 1'b1;
        rsp_fire = 1'b1;
        step();
        exp_at(cyc, K_PEND, 5, "pending_both_fire");
        repeat (10) begin
            req_fire = 1'b1;
            step();
        end
        exp_at(cyc, K_PEND,   15, "pending_15");
        exp_at(cyc, K_REQRDY, 1,  "req_ready_at_15");
        req_fire = 1'b1;
        step();
        exp_at(cyc, K_PEND,   16, "pending_full");
        exp_at(cyc, K_REQRDY, 0,  "req_ready_full");
        repeat (14) begin
            rsp_fire = 1'b1;
            step();
        end
        exp_at(cyc, K_PEND,   2, "pending_2");
        exp_at(cyc, K_REQRDY, 1, "req_ready_at_2");

        // reset in the middle of a drain (cycle 54)
        wr(0, 0, 32'h0000_ABCD);
        commit_valid = 1'b1;
        step();
        exp_at(cyc, K_DONE, 0, "drain2_no_done");
        exp_at(cyc, K_CRDY, 0, "drain2_commit_ready");
        exp_at(cyc, K_ACT,  32'h1000_0000, "drain2_active_held", 0, 0);
        reset = 1'b1;
        step();
        exp_at(cyc, K_PEND,   0, "midreset_pending");
        exp_at(cyc, K_CRDY,   1, "midreset_commit_ready");
        exp_at(cyc, K_REQRDY, 1, "midreset_req_ready");
        exp_at(cyc, K_DONE,   0, "midreset_no_done");
        exp_at(cyc, K_RD,     0, "midreset_rd_data");
        exp_at(cyc, K_ACT,    0, "midreset_active_s0", 0, 0);
        exp_at(cyc, K_ACT,    0, "midreset_active_s1", 1, 1);
        reset = 1'b0;
        rd_exp(0, 0, 0, "midreset_shadow_cleared");
        exp_at(cyc + 1, K_DONE, 0, "midreset_no_late_done");
        exp_at(cyc + 2, K_DONE, 0, "midreset_no_late_done2");
        exp_at(cyc + 2, K_ACT,  0, "midreset_no_late_copy", 0, 0);
        step();
        step();
        step();

        @(negedge clk);
        #1;
        foreach (sbq[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked (due cycle %0d)", sbq[i].name, sbq[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
